// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: fixed-priority (lowest pipe ID wins) sharing of the single GPR write port.
// Optional anti-starvation promotion is enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int NUM_PIPES    = 4,
    parameter int REG_WIDTH    = 5,
    parameter int STARVE_LIMIT = 8,
    localparam int ID_W        = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PIPES-1:0]           exe_valid_i,
    input  logic [NUM_PIPES-1:0]           exe_reg_write_i,
    input  logic [NUM_PIPES*REG_WIDTH-1:0] exe_rd_i,
    input  logic [NUM_PIPES*32-1:0]        exe_data_i,
    output logic [NUM_PIPES-1:0]           exe_ready_o,
    output logic                           wb_wr_en_o,
    output logic [REG_WIDTH-1:0]           wb_rd_o,
    output logic [31:0]                    wb_wr_data_o,
    output logic [ID_W-1:0]                wb_grant_id_o,
    output logic                           wb_conflict_o
);

    logic [REG_WIDTH-1:0] rd_lane   [NUM_PIPES];
    logic [31:0]          data_lane [NUM_PIPES];
    logic [NUM_PIPES-1:0] writer;
    logic [NUM_PIPES-1:0] starved;
    logic [NUM_PIPES-1:0] cand_mask;
    logic [NUM_PIPES-1:0] grant;
    logic [ID_W-1:0]      win_id;
    logic                 any_writer;
    logic                 multi_writer;

    // x0 is hard-wired, so an rd==0 result is treated like a store: accepted, never written.
    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_lane
        assign rd_lane[gi]   = exe_rd_i[gi*REG_WIDTH +: REG_WIDTH];
        assign data_lane[gi] = exe_data_i[gi*32 +: 32];
        assign writer[gi]    = exe_valid_i[gi] & exe_reg_write_i[gi] & (rd_lane[gi] != '0);
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_starve
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        assign starved[gi] = (cnt_q == CNT_W'(STARVE_LIMIT));

        always_comb begin
            cnt_d = '0;
            if (writer[gi] && !grant[gi]) begin
                cnt_d = starved[gi] ? cnt_q : cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end
`else
    assign starved = '0;
`endif

    // Starved writers, when present, form the candidate set; otherwise every writer competes.
    always_comb begin
        cand_mask    = ((writer & starved) != '0) ? (writer & starved) : writer;
        any_writer   = (writer != '0);
        multi_writer = ((writer & (writer - 1'b1)) != '0);
        win_id       = '0;
        for (int p = NUM_PIPES - 1; p >= 0; p--) begin
            if (cand_mask[p]) begin
                win_id = ID_W'(p);
            end
        end
        grant = '0;
        if (any_writer) begin
            grant[win_id] = 1'b1;
        end
    end

    assign exe_ready_o = rst ? '0 : (exe_valid_i & (~writer | grant));

    logic                 wr_en_q,    wr_en_d;
    logic [REG_WIDTH-1:0] rd_q,       rd_d;
    logic [31:0]          data_q,     data_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 conflict_q, conflict_d;

    always_comb begin
        wr_en_d    = any_writer;
        conflict_d = multi_writer;
        rd_d       = rd_q;
        data_d     = data_q;
        grant_id_d = grant_id_q;
        if (any_writer) begin
            rd_d       = rd_lane[win_id];
            data_d     = data_lane[win_id];
            grant_id_d = win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q    <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            grant_id_q <= '0;
            conflict_q <= 1'b0;
        end else begin
            wr_en_q    <= wr_en_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
            conflict_q <= conflict_d;
        end
    end

    assign wb_wr_en_o    = wr_en_q;
    assign wb_rd_o       = rd_q;
    assign wb_wr_data_o  = data_q;
    assign wb_grant_id_o = grant_id_q;
    assign wb_conflict_o = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a per-pipe request model drives traffic, expected writes
// are queued at handshake time and a separate monitor checks the registered writeback port.
module tb_wb_port_arbiter;
    localparam int NP    = 4;
    localparam int RW    = 5;
    localparam int LIMIT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     exe_valid_i = '0;
    logic [NP-1:0]     exe_reg_write_i = '0;
    logic [NP*RW-1:0]  exe_rd_i = '0;
    logic [NP*32-1:0]  exe_data_i = '0;
    logic [NP-1:0]     exe_ready_o;
    logic              wb_wr_en_o;
    logic [RW-1:0]     wb_rd_o;
    logic [31:0]       wb_wr_data_o;
    logic [1:0]        wb_grant_id_o;
    logic              wb_conflict_o;

    wb_port_arbiter #(.NUM_PIPES(NP), .REG_WIDTH(RW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .exe_valid_i(exe_valid_i), .exe_reg_write_i(exe_reg_write_i),
        .exe_rd_i(exe_rd_i), .exe_data_i(exe_data_i), .exe_ready_o(exe_ready_o),
        .wb_wr_en_o(wb_wr_en_o), .wb_rd_o(wb_rd_o), .wb_wr_data_o(wb_wr_data_o),
        .wb_grant_id_o(wb_grant_id_o), .wb_conflict_o(wb_conflict_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endfunction

    // Pending request held by each pipe until accepted.
    bit         pend [NP];
    bit         prw  [NP];
    logic [4:0] prd  [NP];
    logic [31:0] pdat [NP];
    int         loss [NP];
    bit         stream_alu = 0;
    logic [NP-1:0] dut_ready;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  id;
        logic        conflict;
    } exp_t;
    exp_t sbq[$];

    task automatic set_req(input int p, input bit rw, input logic [4:0] rd, input logic [31:0] d);
        pend[p] = 1; prw[p] = rw; prd[p] = rd; pdat[p] = d;
    endtask

    // One clock of stimulus plus the reference decision for that clock.
    task automatic cycle(input bit rst_val, input int spawn_pct);
        int writers[$];
        int winner;
        logic [NP-1:0] exp_ready;
        @(negedge clk);
        rst = rst_val;
        for (int p = 0; p < NP; p++) begin
            if (!pend[p] && p == 0 && stream_alu) begin
                set_req(0, 1, 5'($urandom_range(31, 1)), $urandom);
            end else if (!pend[p] && int'($urandom_range(99)) < spawn_pct) begin
                set_req(p, $urandom_range(3) != 0,
                        ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)), $urandom);
            end
            exe_valid_i[p]         = pend[p];
            exe_reg_write_i[p]     = pend[p] ? prw[p] : 1'($urandom);
            exe_rd_i[p*RW +: RW]   = pend[p] ? prd[p] : 5'($urandom);
            exe_data_i[p*32 +: 32] = pend[p] ? pdat[p] : $urandom;
        end
        for (int p = 0; p < NP; p++)
            if (pend[p] && prw[p] && prd[p] != 0) writers.push_back(p);
        winner = -1;
`ifdef WB_ARB_STARVE_GUARD_EN
        foreach (writers[i])
            if (winner < 0 && loss[writers[i]] == LIMIT) winner = writers[i];
`endif
        if (winner < 0 && writers.size() > 0) winner = writers[0];
        exp_ready = '0;
        for (int p = 0; p < NP; p++) begin
            bit is_w = pend[p] && prw[p] && prd[p] != 0;
            exp_ready[p] = !rst_val && pend[p] && (!is_w || p == winner);
        end
        #1;
        dut_ready = exe_ready_o;
        check("ready", 64'(exe_ready_o), 64'(exp_ready));
        if (rst_val) begin
            for (int p = 0; p < NP; p++) loss[p] = 0;
        end else begin
            if (winner >= 0)
                sbq.push_back('{rd: prd[winner], data: pdat[winner], id: 2'(winner),
                                conflict: writers.size() >= 2});
            for (int p = 0; p < NP; p++) begin
                bit is_w = pend[p] && prw[p] && prd[p] != 0;
                if (is_w && p != winner) loss[p] = (loss[p] < LIMIT) ? loss[p] + 1 : LIMIT;
                else loss[p] = 0;
                if (exp_ready[p]) pend[p] = 0;
            end
        end
    endtask

    // Monitor: consumes the queue whenever the registered port shows a write.
    bit         mon_en = 1;
    exp_t       held = '0;
    initial begin
        bit r;
        exp_t e;
        while (mon_en) begin
            @(posedge clk);
            r = rst;
            #1;
            if (r) begin
                check("reset_out", {wb_wr_en_o, wb_rd_o, wb_wr_data_o, wb_grant_id_o, wb_conflict_o}, '0);
                held = '0;
            end else if (wb_wr_en_o) begin
                if (sbq.size() == 0) begin
                    check("spurious_write", 64'(wb_rd_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    check("write", {wb_rd_o, wb_wr_data_o, wb_grant_id_o, wb_conflict_o}, 64'(e));
                    held = e;
                end
            end else begin
                check("idle_hold", {wb_rd_o, wb_wr_data_o, wb_grant_id_o, wb_conflict_o},
                      64'({held.rd, held.data, held.id, 1'b0}));
            end
        end
    end

    initial begin
        int accept_at;
        int alu_stalls;
        for (int p = 0; p < NP; p++) begin pend[p] = 0; loss[p] = 0; end

        // Reset with every pipe presenting a write: nothing may be accepted.
        for (int p = 0; p < NP; p++) set_req(p, 1, 5'(p + 10), 32'(p + 100));
        cycle(1, 0);
        cycle(1, 0);
        repeat (6) cycle(0, 0);

        // Single MUL write.
        set_req(2, 1, 5'd7, 32'hDEAD_BEEF);
        cycle(0, 0);
        check("mul_ready", 64'(dut_ready[2]), 64'd1);
        repeat (2) cycle(0, 0);

        // Three-way collision drains in priority order.
        set_req(0, 1, 5'd1, 32'd1);
        set_req(1, 1, 5'd2, 32'd2);
        set_req(3, 1, 5'd3, 32'd3);
        repeat (4) cycle(0, 0);

        // Store, rd==0 write and a real write all accepted together.
        set_req(1, 0, 5'd4, 32'h5555);
        set_req(0, 1, 5'd0, 32'h6666);
        set_req(2, 1, 5'd5, 32'h7777);
        cycle(0, 0);
        check("bypass_ready", 64'(dut_ready), 64'b0111);
        repeat (2) cycle(0, 0);

        // Streaming ALU versus a DIV write.
        stream_alu = 1;
        set_req(3, 1, 5'd9, 32'h9999_0009);
        accept_at = 0;
        alu_stalls = 0;
        for (int c = 1; c <= 30; c++) begin
            cycle(0, 0);
            if (accept_at == 0 && dut_ready[3]) accept_at = c;
            if (c <= 9 && !dut_ready[0]) alu_stalls++;
        end
`ifdef WB_ARB_STARVE_GUARD_EN
        check("starve_grant_cycle", 64'(accept_at), 64'd9);
        check("alu_stall_cycles", 64'(alu_stalls), 64'd1);
`else
        check("div_starved", 64'(accept_at), 64'd0);
        check("alu_never_stalled", 64'(alu_stalls), 64'd0);
`endif
        stream_alu = 0;
        repeat (4) cycle(0, 0);

        // Reset pulsed the cycle after a grant, with a losing writer accumulating history.
        stream_alu = 1;
        set_req(3, 1, 5'd11, 32'hAB);
        repeat (5) cycle(0, 0);
        cycle(1, 0);
        stream_alu = 0;
        repeat (5) cycle(0, 0);

        // Randomised traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 100) stream_alu = 1;
            if (c % 500 == 200) stream_alu = 0;
            cycle($urandom_range(199) == 0, 45);
        end
        stream_alu = 0;
        repeat (12) cycle(0, 0);
        repeat (2) @(negedge clk);
        check("queue_drained", 64'(sbq.size()), 64'd0);
        mon_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
